// File: rtl/vga_scan_scheduler.sv
// vga_scan_scheduler: VGA raster counters plus a single framebuffer port that is
// shared between display tile reads (active area) and buffered game-logic
// writes (drained only in blanking cycles, in acceptance order).

// Default 640x480@60 timing; these mirror the shared vga_params definitions and
// are only supplied here when no one else has defined them.
`ifndef HACTIVE
`define HACTIVE 640
`endif
`ifndef HFRONTPORCH
`define HFRONTPORCH 16
`endif
`ifndef HSYNCPULSE
`define HSYNCPULSE 96
`endif
`ifndef HBACKPORCH
`define HBACKPORCH 48
`endif
`ifndef VACTIVE
`define VACTIVE 480
`endif
`ifndef VFRONTPORCH
`define VFRONTPORCH 10
`endif
`ifndef VSYNCPULSE
`define VSYNCPULSE 2
`endif
`ifndef VBACKPORCH
`define VBACKPORCH 33
`endif

module vga_scan_scheduler #(
  parameter int DATA_W     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int H_ACTIVE   = `HACTIVE,
  parameter int H_FRONT    = `HFRONTPORCH,
  parameter int H_SYNC     = `HSYNCPULSE,
  parameter int H_BACK     = `HBACKPORCH,
  parameter int V_ACTIVE   = `VACTIVE,
  parameter int V_FRONT    = `VFRONTPORCH,
  parameter int V_SYNC     = `VSYNCPULSE,
  parameter int V_BACK     = `VBACKPORCH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [10:0]       wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [9:0]        row,
  output logic [9:0]        col,
  output logic              frame_tick,
  output logic [10:0]       fb_addr,
  output logic              fb_we,
  output logic [DATA_W-1:0] fb_wdata
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  // Tiles are 16x16 pixels, so one tile row spans H_ACTIVE/16 entries (40 by default).
  localparam int TILES_W = H_ACTIVE / 16;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int ENTRY_W = 11 + DATA_W;

  logic [9:0]         row_reg;
  logic [9:0]         col_reg;
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [ENTRY_W-1:0] mem_reg [FIFO_DEPTH];

  logic               row_last;
  logic               col_last;
  logic               display_slot;
  logic               push;
  logic               pop;
  logic [10:0]        tile_addr;
  logic [ENTRY_W-1:0] head;

  assign row_last     = (row_reg == 10'(H_TOTAL - 1));
  assign col_last     = (col_reg == 10'(V_TOTAL - 1));
  assign display_slot = (row_reg < 10'(H_ACTIVE)) && (col_reg < 10'(V_ACTIVE));

  // Ready looks only at the registered occupancy, so a pop in this cycle never
  // opens room for a push on the same edge.
  assign wr_ready = (count_reg < CNT_W'(FIFO_DEPTH));
  assign push     = wr_valid & wr_ready;
  assign pop      = ~display_slot & (count_reg != '0);

  assign head      = mem_reg[rd_ptr_reg];
  assign tile_addr = 11'(col_reg[9:4]) * 11'(TILES_W) + 11'(row_reg[9:4]);

  assign row        = row_reg;
  assign col        = col_reg;
  assign frame_tick = (row_reg == '0) && (col_reg == 10'(V_ACTIVE));

  // Raster scan: row advances every cycle, col advances when row wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_reg <= '0;
      col_reg <= '0;
    end else if (row_last) begin
      row_reg <= '0;
      col_reg <= col_last ? '0 : col_reg + 10'd1;
    end else begin
      row_reg <= row_reg + 10'd1;
    end
  end

  // Write buffer storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_reg[wr_ptr_reg] <= {wr_addr, wr_data};
  end

  // Buffer pointers and occupancy; reset drops every pending write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (push && !pop)      count_reg <= count_reg + CNT_W'(1);
      else if (pop && !push) count_reg <= count_reg - CNT_W'(1);
    end
  end

  // Port mux: display cycles read the current tile, free cycles drain the head or idle at 0.
  always_comb begin
    fb_we    = pop;
    fb_addr  = '0;
    fb_wdata = '0;
    if (display_slot) begin
      fb_addr = tile_addr;
    end else if (pop) begin
      fb_addr  = head[ENTRY_W-1:DATA_W];
      fb_wdata = head[DATA_W-1:0];
    end
  end

endmodule
